// File: rtl/mux_arb_nto1.sv
// N-to-1 registered mux/arbiter: fixed-select or round-robin grant into a single-entry output stage.
// Optional MUX_ARB_BEAT_COUNT_EN adds a saturating output-beat counter port (beat_count).
module mux_arb_nto1 #(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 4,
    localparam int SELW   = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SELW-1:0]         sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SELW-1:0]         out_chan,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef MUX_ARB_BEAT_COUNT_EN
    ,
    output logic [31:0]             beat_count
`endif
);

    logic [NUM_IN-1:0][WIDTH-1:0] in_arr;
    logic [NUM_IN-1:0]            grant;
    logic [SELW-1:0]              gnt_idx;
    logic [WIDTH-1:0]             gnt_data;
    logic                         found;
    logic                         load_en;
    logic                         xfer;

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_chan_q,  out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;

    assign in_arr  = in_data;
    assign load_en = !out_valid_q || out_ready;

    // Round-robin walks offsets 1..NUM_IN past the last winner; an out-of-range sel matches nothing.
    always_comb begin
        grant    = '0;
        gnt_idx  = '0;
        gnt_data = '0;
        found    = 1'b0;
        if (!mode) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (in_valid[i] && sel == SELW'(i)) begin
                    grant[i] = 1'b1;
                    gnt_idx  = SELW'(i);
                    gnt_data = in_arr[i];
                end
            end
        end else begin
            for (int k = 1; k <= NUM_IN; k++) begin
                for (int i = 0; i < NUM_IN; i++) begin
                    if (!found && in_valid[i] && ((int'(rr_ptr_q) + k) % NUM_IN) == i) begin
                        found    = 1'b1;
                        grant[i] = 1'b1;
                        gnt_idx  = SELW'(i);
                        gnt_data = in_arr[i];
                    end
                end
            end
        end
    end

    assign in_ready = (reset || !load_en) ? '0 : grant;
    assign xfer     = |in_ready;

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_data_d  = gnt_data;
            out_chan_d  = gnt_idx;
            out_valid_d = 1'b1;
            if (mode) rr_ptr_d = gnt_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= SELW'(NUM_IN - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

`ifdef MUX_ARB_BEAT_COUNT_EN
    logic [31:0] beat_cnt_q, beat_cnt_d;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (out_valid_q && out_ready && beat_cnt_q != 32'hFFFF_FFFF) beat_cnt_d = beat_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) beat_cnt_q <= '0;
        else       beat_cnt_q <= beat_cnt_d;
    end

    assign beat_count = beat_cnt_q;
`endif

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Self-checking bench for mux_arb_nto1: directed scenarios plus randomized traffic against a cycle model.
module tb_mux_arb_nto1;
    localparam int WIDTH  = 32;
    localparam int NUM_IN = 4;
    localparam int SELW   = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NUM_IN-1:0][WIDTH-1:0] din;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0] in_valid;
    logic [NUM_IN-1:0] in_ready;
    logic mode;
    logic [SELW-1:0] sel;
    logic [WIDTH-1:0] out_data;
    logic [SELW-1:0] out_chan;
    logic out_valid;
    logic out_ready;
`ifdef MUX_ARB_BEAT_COUNT_EN
    logic [31:0] beat_count;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state
    bit          m_valid;
    logic [31:0] m_data;
    int          m_chan;
    int          m_ptr;
    logic [31:0] m_cnt;

    assign in_data = din;
    always #5 clk = ~clk;

    mux_arb_nto1 #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .sel(sel), .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef MUX_ARB_BEAT_COUNT_EN
        , .beat_count(beat_count)
`endif
    );

    function automatic logic [NUM_IN-1:0] exp_ready();
        logic [NUM_IN-1:0] r;
        r = '0;
        if (reset || (m_valid && !out_ready)) return r;
        if (!mode) begin
            if (int'(sel) < NUM_IN && in_valid[sel]) r[sel] = 1'b1;
            return r;
        end
        for (int k = 1; k <= NUM_IN; k++) begin
            int c;
            c = (m_ptr + k) % NUM_IN;
            if (in_valid[c]) begin
                r[c] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic model_tick();
        logic [NUM_IN-1:0] r;
        int c;
        r = exp_ready();
        c = -1;
        for (int i = 0; i < NUM_IN; i++) if (r[i]) c = i;
        if (reset) begin
            m_valid = 0; m_data = 0; m_chan = 0; m_ptr = NUM_IN - 1; m_cnt = 0;
        end else begin
            if (m_valid && out_ready && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (c >= 0) begin
                m_valid = 1; m_data = din[c]; m_chan = c;
                if (mode) m_ptr = c;
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
        end
    endtask

    task automatic advance();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1; in_valid = '0;
        advance();
        reset = 0;
    endtask

    task automatic test_reset();
        mode = 0; sel = 0; in_valid = 4'b1111; out_ready = 1; din = '0;
        advance();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", out_data); end
        checks++; if (out_chan !== 2'd0) begin errors++; $display("FAIL reset_chan got %0d want 0", out_chan); end
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", in_ready); end
        reset = 0;
    endtask

    task automatic test_fixed();
        mode = 0; sel = 2; in_valid = 4'b0100; din = '0; din[2] = 32'h0000_00D2; out_ready = 1;
        #1;
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL fixed_ready got %b want 0100", in_ready); end
        advance();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hD2 || out_chan !== 2'd2) begin
            errors++; $display("FAIL fixed_out got v=%b d=%h c=%0d want v=1 d=d2 c=2", out_valid, out_data, out_chan);
        end
        // Out-of-channel selects are never granted even when valid.
        sel = 1; in_valid = 4'b1101;
        #1;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL fixed_nogrant got %b want 0000", in_ready); end
        advance();
        checks++; if (out_valid !== 1'b0 || out_data !== 32'hD2) begin
            errors++; $display("FAIL fixed_drain got v=%b d=%h want v=0 d=d2", out_valid, out_data);
        end
    endtask

    task automatic test_rr_all();
        do_reset();
        mode = 1; in_valid = 4'b1111; out_ready = 1;
        for (int i = 0; i < NUM_IN; i++) din[i] = i;
        for (int n = 0; n < 6; n++) begin
            advance();
            checks++; if (out_valid !== 1'b1 || out_chan !== SELW'(n % NUM_IN) || out_data !== 32'(n % NUM_IN)) begin
                errors++; $display("FAIL rr_seq[%0d] got v=%b c=%0d d=%h want v=1 c=%0d", n, out_valid, out_chan, out_data, n % NUM_IN);
            end
        end
    endtask

    task automatic test_rr_wrap();
        logic [NUM_IN-1:0] want [3];
        want[0] = 4'b1000; want[1] = 4'b0010; want[2] = 4'b1000;
        do_reset();
        mode = 1; out_ready = 1; in_valid = 4'b0010;
        advance();
        in_valid = 4'b1010;
        for (int n = 0; n < 3; n++) begin
            #1;
            checks++; if (in_ready !== want[n]) begin errors++; $display("FAIL rr_wrap_ready[%0d] got %b want %b", n, in_ready, want[n]); end
            advance();
            checks++; if (out_chan !== SELW'(m_chan)) begin errors++; $display("FAIL rr_wrap_chan[%0d] got %0d want %0d", n, out_chan, m_chan); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        mode = 0; sel = 1; din[1] = 32'h20; in_valid = 4'b0010; out_ready = 1;
        advance();
        out_ready = 0;
        for (int n = 0; n < 3; n++) begin
            in_valid = 4'($urandom_range(1, 15)); mode = 1'($urandom); sel = 2'($urandom);
            for (int i = 0; i < NUM_IN; i++) din[i] = $urandom;
            #1;
            checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got %b want 0000", n, in_ready); end
            advance();
            checks++; if (out_valid !== 1'b1 || out_data !== 32'h20 || out_chan !== 2'd1) begin
                errors++; $display("FAIL bp_hold[%0d] got v=%b d=%h c=%0d want v=1 d=20 c=1", n, out_valid, out_data, out_chan);
            end
        end
        out_ready = 1; mode = 0; sel = 3; in_valid = 4'b1000; din[3] = 32'h33;
        #1;
        checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL bp_release_ready got %b want 1000", in_ready); end
        advance();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h33 || out_chan !== 2'd3) begin
            errors++; $display("FAIL bp_release_out got v=%b d=%h c=%0d want v=1 d=33 c=3", out_valid, out_data, out_chan);
        end
    endtask

    task automatic test_reset_mid();
        mode = 1; in_valid = 4'b1111; out_ready = 0;
        for (int i = 0; i < NUM_IN; i++) din[i] = 32'hA0 + i;
        advance();
        reset = 1;
        #1;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL midrst_ready got %b want 0000", in_ready); end
        advance();
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_chan !== 2'd0) begin
            errors++; $display("FAIL midrst_out got v=%b d=%h c=%0d want 0/0/0", out_valid, out_data, out_chan);
        end
        reset = 0; out_ready = 1;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL midrst_first got %b want 0001", in_ready); end
        advance();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 49) == 0);
            mode = 1'($urandom); sel = 2'($urandom); in_valid = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NUM_IN; i++) din[i] = $urandom;
            #1;
            checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL rand_ready[%0d] got %b want %b", n, in_ready, exp_ready()); end
            advance();
            checks++; if (out_valid !== m_valid || out_data !== m_data || out_chan !== SELW'(m_chan)) begin
                errors++; $display("FAIL rand_out[%0d] got v=%b d=%h c=%0d want v=%b d=%h c=%0d",
                                   n, out_valid, out_data, out_chan, m_valid, m_data, m_chan);
            end
        end
        reset = 0;
    endtask

`ifdef MUX_ARB_BEAT_COUNT_EN
    task automatic test_beat_count();
        do_reset();
        mode = 1; in_valid = 4'b1111; out_ready = 1;
        for (int n = 0; n < 6; n++) advance();
        checks++; if (beat_count !== 32'd5) begin errors++; $display("FAIL beat_five got %0d want 5", beat_count); end
        force dut.beat_cnt_q = 32'hFFFF_FFFD;
        #1;
        release dut.beat_cnt_q;
        m_cnt = 32'hFFFF_FFFD;
        for (int n = 0; n < 4; n++) advance();
        checks++; if (beat_count !== 32'hFFFF_FFFF || beat_count !== m_cnt) begin
            errors++; $display("FAIL beat_sat got %h want ffffffff", beat_count);
        end
    endtask
`endif

    initial begin
        m_valid = 0; m_data = 0; m_chan = 0; m_ptr = NUM_IN - 1; m_cnt = 0;
        mode = 0; sel = 0; in_valid = '0; out_ready = 0; din = '0;
        @(posedge clk); #1;
        test_reset();
        test_fixed();
        test_rr_all();
        test_rr_wrap();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef MUX_ARB_BEAT_COUNT_EN
        test_beat_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
